// File: rtl/bus_xfer_ctrl_if.sv
// Bundle of arbiter grants, per-port data sources and the shared output stream
// for the burst transfer controller.
interface bus_xfer_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              gnt_0, gnt_1, gnt_2, gnt_3;
  logic              valid_0, valid_1, valid_2, valid_3;
  logic [DATA_W-1:0] data_0, data_1, data_2, data_3;
  logic              rdy_0, rdy_1, rdy_2, rdy_3;
  logic              done_0, done_1, done_2, done_3;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        owner;
  logic              busy;
  logic              abrt;
  logic              err;

  // Arbiter, requesters and downstream sink as seen from outside the controller.
  modport master (
    output gnt_0, gnt_1, gnt_2, gnt_3,
    output valid_0, valid_1, valid_2, valid_3,
    output data_0, data_1, data_2, data_3,
    output out_ready,
    input  rdy_0, rdy_1, rdy_2, rdy_3,
    input  done_0, done_1, done_2, done_3,
    input  out_data, out_valid, owner, busy, abrt, err
  );

  // The controller itself.
  modport slave (
    input  gnt_0, gnt_1, gnt_2, gnt_3,
    input  valid_0, valid_1, valid_2, valid_3,
    input  data_0, data_1, data_2, data_3,
    input  out_ready,
    output rdy_0, rdy_1, rdy_2, rdy_3,
    output done_0, done_1, done_2, done_3,
    output out_data, out_valid, owner, busy, abrt, err
  );
endinterface

// File: rtl/bus_xfer_ctrl.sv
// Burst transfer controller: serves the one-hot granted port for BURST_LEN
// beats onto a registered valid/ready output stream, pulses done when the last
// beat leaves, and flags multi-grant (sticky err) and lost-grant (abrt) faults.
module bus_xfer_ctrl #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  bus_xfer_ctrl_if.slave       bus
);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, REL} state_t;

  localparam logic [4:0] LAST_BEAT = 5'(BURST_LEN - 1);

  state_t            state, state_nxt;
  logic [1:0]        owner_q, owner_nxt;
  logic [4:0]        beat_cnt, beat_cnt_nxt;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              err_q;
  logic              err_set;

  logic [3:0]        gnt, valid;
  logic [DATA_W-1:0] data [4];
  logic [2:0]        grant_cnt;
  logic [1:0]        grant_idx;
  logic              gnt_own, valid_own, slot_free, accept, last_beat, abort, other_gnt;
  logic [3:0]        rdy_vec, done_vec;

  assign gnt     = {bus.gnt_3, bus.gnt_2, bus.gnt_1, bus.gnt_0};
  assign valid   = {bus.valid_3, bus.valid_2, bus.valid_1, bus.valid_0};
  assign data[0] = bus.data_0;
  assign data[1] = bus.data_1;
  assign data[2] = bus.data_2;
  assign data[3] = bus.data_3;

  // Count grants and remember the index of the (highest) one seen.
  always_comb begin
    grant_cnt = '0;
    grant_idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (gnt[i]) begin
        grant_cnt = grant_cnt + 3'd1;
        grant_idx = 2'(i);
      end
    end
  end

  // Owner-side handshake terms; rst gates them so nothing is accepted in reset.
  always_comb begin
    gnt_own   = gnt[owner_q];
    valid_own = valid[owner_q];
    slot_free = !out_valid_q || bus.out_ready;
    accept    = rst && (state == XFER) && gnt_own && valid_own && slot_free;
    last_beat = accept && (beat_cnt == LAST_BEAT);
    abort     = rst && (state == XFER) && !gnt_own;
    other_gnt = |(gnt & ~(4'b0001 << owner_q));
  end

  // Next-state, beat counting, fault detection and per-port strobes.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_nxt    = state;
    owner_nxt    = owner_q;
    beat_cnt_nxt = beat_cnt;
    err_set      = 1'b0;
    rdy_vec      = '0;
    done_vec     = '0;

    if (accept) begin
      rdy_vec[owner_q] = 1'b1;
      beat_cnt_nxt     = beat_cnt + 5'd1;
    end

    unique case (state)
      IDLE: begin
        if (grant_cnt == 3'd1) begin
          state_nxt    = XFER;
          owner_nxt    = grant_idx;
          beat_cnt_nxt = '0;
        end else if (grant_cnt > 3'd1) begin
          err_set = 1'b1;
        end
      end
      XFER: begin
        err_set = other_gnt;
        if (!gnt_own) begin
          state_nxt = IDLE;
        end else if (last_beat) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        err_set = other_gnt;
        if (slot_free) begin
          done_vec[owner_q] = rst;
          state_nxt         = REL;
        end
      end
      REL: begin
        err_set = other_gnt;
        if (!gnt_own) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state register with synchronous active-low reset; err is sticky.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking (<=) so every flop samples pre-edge values regardless of block order.
    if (!rst) begin
      state    <= IDLE;
      owner_q  <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      owner_q  <= owner_nxt;
      beat_cnt <= beat_cnt_nxt;
      err_q    <= err_q | err_set;
    end
  end

  // Output register: load on accept, otherwise empty when consumed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= data[owner_q];
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.rdy_0     = rdy_vec[0];
  assign bus.rdy_1     = rdy_vec[1];
  assign bus.rdy_2     = rdy_vec[2];
  assign bus.rdy_3     = rdy_vec[3];
  assign bus.done_0    = done_vec[0];
  assign bus.done_1    = done_vec[1];
  assign bus.done_2    = done_vec[2];
  assign bus.done_3    = done_vec[3];
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = (state != IDLE);
  assign bus.abrt      = abort;
  assign bus.err       = err_q;

endmodule
